// File: rtl/multi_stream_mac.sv
// ---------------------------------------------------------------------------------------------
// multi_stream_mac
//
// Round-robin multiply-accumulate over NUM_CH AXI-Stream input channels that share a single
// weight stream. One channel is granted per vector. Each accepted beat adds in[g] * w to a
// signed accumulator. The vector closes on tlast, or when the beat count reaches max_len
// (if max_len is non-zero). The closing beat loads act(acc + product + bias), reduced to
// OUT_WIDTH, into the output register.
//
// Optional feature macro: MULTI_STREAM_MAC_SAT_EN
//   defined   -> the result saturates to the signed OUT_WIDTH range
//   undefined -> the result keeps the low OUT_WIDTH bits (wraps)
//
// Ports
//   ap_clk, ap_rst         : clock and synchronous active-high reset
//   s_axis_in_*            : per-channel input streams (tdata channel i at [i*IN_WIDTH +: IN_WIDTH])
//   s_axis_w_*             : shared weight stream
//   m_axis_out_*           : result stream; tuser carries the source channel
//   cfg_we/addr/wdata/rdata: register port, combinational read
//     addr 0 act_mode[0] (0 ReLU, 1 pass), addr 1 bias, addr 2 max_len[15:0],
//     addr 3 status {err_ch[7:4], err[0]}; any write to addr 3 clears it
// ---------------------------------------------------------------------------------------------
module multi_stream_mac #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_CH*IN_WIDTH-1:0]   s_axis_in_tdata,
  input  logic [NUM_CH-1:0]            s_axis_in_tvalid,
  output logic [NUM_CH-1:0]            s_axis_in_tready,
  input  logic [NUM_CH-1:0]            s_axis_in_tlast,
  input  logic [W_WIDTH-1:0]           s_axis_w_tdata,
  input  logic                         s_axis_w_tvalid,
  output logic                         s_axis_w_tready,
  output logic [OUT_WIDTH-1:0]         m_axis_out_tdata,
  output logic [$clog2(NUM_CH)-1:0]    m_axis_out_tuser,
  output logic                         m_axis_out_tvalid,
  input  logic                         m_axis_out_tready,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_addr,
  input  logic [31:0]                  cfg_wdata,
  output logic [31:0]                  cfg_rdata
);

  localparam int unsigned ChW   = $clog2(NUM_CH);
  localparam int unsigned ProdW = IN_WIDTH + W_WIDTH;

  typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

  state_e r_state, w_state_next;

  logic [ChW-1:0]              r_grant, r_last_grant;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [15:0]                 r_cnt;
  logic [OUT_WIDTH-1:0]        r_out_data;
  logic [ChW-1:0]              r_out_user;

  logic                        r_act_mode;
  logic signed [31:0]          r_bias;
  logic [15:0]                 r_max_len;
  logic                        r_err;
  logic [3:0]                  r_err_ch;

  logic [ChW-1:0]              w_rr_grant, w_rr_idx;
  logic                        w_rr_found;
  logic signed [IN_WIDTH-1:0]  w_in_g;
  logic signed [W_WIDTH-1:0]   w_wt;
  logic signed [ProdW-1:0]     w_prod;
  logic signed [ACC_WIDTH-1:0] w_acc_sum, w_final, w_act;
  logic [OUT_WIDTH-1:0]        w_result;
  logic [15:0]                 w_cnt_inc;
  logic                        w_beat, w_len_hit, w_last_beat, w_len_err;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid channel at or after last_grant + 1 (mod NUM_CH)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rr_grant = r_last_grant;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      w_rr_idx = ChW'((int'(r_last_grant) + k) % int'(NUM_CH));
      if (!w_rr_found && s_axis_in_tvalid[w_rr_idx]) begin
        w_rr_found = 1'b1;
        w_rr_grant = w_rr_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign w_in_g    = s_axis_in_tdata[r_grant*IN_WIDTH +: IN_WIDTH];
  assign w_wt      = s_axis_w_tdata;
  assign w_prod    = w_in_g * w_wt;
  assign w_acc_sum = r_acc + ACC_WIDTH'(w_prod);
  // Bias joins only on the closing beat; it never enters the accumulator.
  assign w_final   = w_acc_sum + ACC_WIDTH'(r_bias);
  assign w_act     = (!r_act_mode && w_final[ACC_WIDTH-1]) ? '0 : w_final;

`ifdef MULTI_STREAM_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SatMax =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SatMin =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  always_comb begin
    if (w_act > SatMax) begin
      w_result = SatMax[OUT_WIDTH-1:0];
    end else if (w_act < SatMin) begin
      w_result = SatMin[OUT_WIDTH-1:0];
    end else begin
      w_result = w_act[OUT_WIDTH-1:0];
    end
  end
`else
  assign w_result = w_act[OUT_WIDTH-1:0];
`endif

  assign w_beat      = (r_state == StAccum) && s_axis_in_tvalid[r_grant] && s_axis_w_tvalid;
  assign w_cnt_inc   = r_cnt + 16'd1;
  assign w_len_hit   = (r_max_len != 16'd0) && (w_cnt_inc == r_max_len);
  assign w_last_beat = w_beat && (s_axis_in_tlast[r_grant] || w_len_hit);
  // A vector cut short by max_len leaves the rest of the packet for a later grant.
  assign w_len_err   = w_last_beat && w_len_hit && !s_axis_in_tlast[r_grant];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_rr_found) w_state_next = StAccum;
      StAccum: if (w_last_beat) w_state_next = StEmit;
      StEmit:  if (m_axis_out_tready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    s_axis_in_tready  = '0;
    s_axis_w_tready   = 1'b0;
    m_axis_out_tvalid = 1'b0;
    case (r_state)
      StAccum: begin
        s_axis_in_tready[r_grant] = s_axis_w_tvalid;
        s_axis_w_tready           = s_axis_in_tvalid[r_grant];
      end
      StEmit:  m_axis_out_tvalid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulator, grant and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_grant      <= '0;
      r_last_grant <= ChW'(NUM_CH - 1);
      r_acc        <= '0;
      r_cnt        <= '0;
      r_out_data   <= '0;
      r_out_user   <= '0;
    end else begin
      if (r_state == StIdle && w_rr_found) begin
        r_grant <= w_rr_grant;
        r_acc   <= '0;
        r_cnt   <= '0;
      end
      if (w_beat) begin
        r_acc <= w_acc_sum;
        r_cnt <= w_cnt_inc;
      end
      if (w_last_beat) begin
        r_out_data <= w_result;
        r_out_user <= r_grant;
      end
      if (r_state == StEmit && m_axis_out_tready) begin
        r_last_grant <= r_grant;
      end
    end
  end

  assign m_axis_out_tdata = r_out_data;
  assign m_axis_out_tuser = r_out_user;

  // ---------------------------------------------------------------------------
  // Configuration / status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_act_mode <= 1'b0;
      r_bias     <= '0;
      r_max_len  <= '0;
      r_err      <= 1'b0;
      r_err_ch   <= '0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: r_act_mode <= cfg_wdata[0];
          2'd1: r_bias     <= cfg_wdata;
          2'd2: r_max_len  <= cfg_wdata[15:0];
          2'd3: begin
            r_err    <= 1'b0;
            r_err_ch <= '0;
          end
          default: ;
        endcase
      end
      // A fresh error wins over a same-cycle clear so it is never lost.
      if (w_len_err) begin
        r_err    <= 1'b1;
        r_err_ch <= 4'(r_grant);
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata = {31'd0, r_act_mode};
      2'd1:    cfg_rdata = r_bias;
      2'd2:    cfg_rdata = {16'd0, r_max_len};
      default: cfg_rdata = {24'd0, r_err_ch, 3'd0, r_err};
    endcase
  end

endmodule

// File: doc/multi_stream_mac.md
MULTI_STREAM_MAC -- requirements
Module: multi_stream_mac

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of input streams, range 2-16.
REQ-002 SHALL have parameter IN_WIDTH, default 8: signed input element width.
REQ-003 SHALL have parameter W_WIDTH, default 8: signed weight element width.
REQ-004 SHALL have parameter ACC_WIDTH, default 32: signed accumulator width, at least IN_WIDTH+W_WIDTH+8.
REQ-005 SHALL have parameter OUT_WIDTH, default 16: signed output width, at most ACC_WIDTH.
REQ-006 SHALL have ports ap_clk (in, 1, sole clock) and ap_rst (in, 1, synchronous active-high reset).
REQ-007 SHALL have ports s_axis_in_tdata (in, NUM_CH*IN_WIDTH, channel i at bits [i*IN_WIDTH +: IN_WIDTH]), s_axis_in_tvalid / s_axis_in_tready / s_axis_in_tlast (in/out/in, NUM_CH each, per channel).
REQ-008 SHALL have ports s_axis_w_tdata (in, W_WIDTH, weights), s_axis_w_tvalid (in, 1), s_axis_w_tready (out, 1).
REQ-009 SHALL have ports m_axis_out_tdata (out, OUT_WIDTH, result), m_axis_out_tuser (out, clog2(NUM_CH), source channel), m_axis_out_tvalid (out, 1), m_axis_out_tready (in, 1).
REQ-010 SHALL have ports cfg_we (in, 1), cfg_addr (in, 2), cfg_wdata (in, 32), cfg_rdata (out, 32, combinational read of cfg_addr).

Function
REQ-011 Registers: addr 0 act_mode[0] (0 ReLU, 1 pass-through); addr 1 bias (signed 32, sign-extended/truncated to ACC_WIDTH); addr 2 max_len[15:0]; addr 3 status {err_ch[7:4], err[0]}, any write clears it.
REQ-012 FSM states: IDLE, ACCUM, EMIT.
REQ-013 IDLE: when any s_axis_in_tvalid is high, grant the lowest index at or after (last_grant+1) mod NUM_CH, clear the accumulator, clear the beat counter, and go to ACCUM next cycle. With no valid input, remain in IDLE.
REQ-014 ACCUM: s_axis_in_tready[g] = s_axis_w_tvalid; s_axis_w_tready = s_axis_in_tvalid[g]; all other in_tready are 0. A beat occurs only when both valids are high.
REQ-015 Each beat: acc <= acc + sext(in[g]) * sext(w); beat counter increments. Accumulation wraps modulo 2^ACC_WIDTH.
REQ-016 A beat with tlast, or a beat that brings the count to max_len (max_len≠0), loads the output register with act(acc + product + bias) in that edge; state goes to EMIT; m_axis_out_tvalid rises on the next cycle (1-cycle latency from the last beat).
REQ-017 Termination by max_len without tlast: status err=1 and err_ch=g. The remaining input beats up to tlast are then consumed by a later grant of the same channel as a new vector.
REQ-018 ReLU: negative sum gives 0. Pass-through: the sum unchanged. The result is then reduced to OUT_WIDTH per REQ-024.
REQ-019 EMIT: hold tdata and tuser stable while tvalid && !tready; on handshake, last_grant <= g and go to IDLE. Back-to-back vectors incur 1 IDLE cycle.
REQ-020 Config writes during ACCUM/EMIT take effect on the next cycle; the bias is sampled at the final beat only.

Reset
REQ-021 While ap_rst is high at an ap_clk edge: state IDLE, last_grant NUM_CH-1 (first grant favours ch0), acc 0, counter 0, all tready and m_axis_out_tvalid 0, tdata 0, tuser 0, act_mode 0, bias 0, max_len 0, status 0.
REQ-022 Reset mid-vector SHALL discard the partial sum and any pending output without emitting it.
REQ-023 Outputs SHALL be driven to their reset values in the cycle after the reset edge.

Configuration
REQ-024 Macro MULTI_STREAM_MAC_SAT_EN: when defined, the result saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. When undefined, the result takes the low OUT_WIDTH bits (wrap).

Verification
REQ-025 ch1 sends 3,-2,5 with tlast, weights 2,4,1, bias 10, ReLU -> single output 13, tuser 1, tvalid 1 cycle after the last beat.
REQ-026 ch0 and ch2 both valid from IDLE after reset -> ch0 served first, then ch2; tuser sequence 0,2; no interleaved beats.
REQ-027 Sum -40, ReLU -> 0; same stimulus in pass-through -> -40 (0xFFD8 at OUT_WIDTH 16).
REQ-028 Sum 40000, OUT_WIDTH 16 -> 32767 with SAT_EN defined, -25536 without.
REQ-029 max_len 2, ch3 sends 4 beats with tlast on the 4th -> two outputs, both tuser 3; status reads 0x31; a write to addr 3 returns 0.
REQ-030 m_axis_out_tready held low 5 cycles -> tdata/tuser stable, no input beats accepted; ap_rst asserted during ACCUM -> no output, all tready 0 next cycle.
